dmem_bus_master: RTL and testbench
==================================

Name: dmem_bus_master

Overview:
- Processor-side initiator for the data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load/store request at a time from the MEM stage and runs the bus handshake until the memory responds with ACKD_n low.
- Places store data on the correct byte lanes and sign- or zero-extends load data.
- Returns a single-cycle response with error reporting for misalignment and bus timeout.

Parameters:
- BIT_WIDTH, 32, data/address width.
- TIMEOUT, 256, maximum number of BUS-state cycles to wait for ACKD_n before aborting with error.
- CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  block is IDLE and accepts the request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  bus encoding: 00 word, 01 halfword, 10/11 byte.
- req_signed  in  1  sign-extend load result (halfword/byte only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access or timeout.
- busy  out  1  state != IDLE.
- DAD  out  32  data bus address.
- MREQ  out  1  bus request.
- WRITE  out  1  1 = write cycle.
- SIZE  out  2  access size, same encoding as req_size.
- ACKD_n  in  1  memory acknowledge, active low.
- DDT  inout  32  data bus; driven only during a write cycle, otherwise high-Z.

Behaviour:
- States: IDLE, BUS, DONE. All outputs are registered except DDT, which is driven from the registered write data gated by MREQ&WRITE.
- Reset values: state IDLE; MREQ=0; WRITE=0; SIZE=00; DAD=0; resp_valid=0; resp_rdata=0; resp_err=0; timeout counter=0; DDT=Z.
- Reset mid-transaction abandons the access. MREQ is 0 after the reset edge and no resp_valid is produced.
- IDLE:
  - req_ready=1.
  - On req_valid, misalignment is checked: size 00 with addr[1:0]!=0, or size 01 with addr[0]!=0.
  - If misaligned: go to DONE with resp_err=1, resp_rdata=0; MREQ is never asserted.
  - Otherwise: latch addr/size/write/signed/wdata, load DAD/SIZE/WRITE, set MREQ=1, clear counter, go to BUS.
- BUS:
  - MREQ, DAD, SIZE and WRITE are held stable.
  - ACKD_n is sampled each rising edge.
  - ACKD_n=0: capture DDT for a load; go to DONE with resp_err=0; MREQ=0 at the same edge.
  - ACKD_n=1: counter increments. If the counter reaches TIMEOUT-1, go to DONE with resp_err=1, resp_rdata=0, MREQ=0.
- DONE:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next edge returns to IDLE and clears resp_valid.
  - resp_rdata and resp_err hold until the next response is produced.
- Minimum load/store latency with single-cycle memory:
  - accept at edge 0;
  - MREQ high during cycle 1;
  - ack sampled at edge 1;
  - resp_valid high during cycle 2.
  - A new request can be accepted at edge 3, so at least one MREQ-low cycle always separates bus accesses.
- Store lane placement on DDT:
  - word: wdata[31:0];
  - halfword: {16'b0, wdata[15:0]};
  - byte: {24'b0, wdata[7:0]}.
  - Memory resolves big-endian byte placement from DAD.
- Load extraction from DDT:
  - word: DDT[31:0];
  - halfword: DDT[15:0] extended;
  - byte: DDT[7:0] extended.
  - Extension is sign when req_signed=1, zero otherwise; req_signed is ignored for word.
- ACKD_n low while in IDLE or DONE is ignored.
- req_valid while not IDLE is ignored (req_ready=0); the requester must hold the request.
- Stores to 0xF000_0000 (console) and 0xFF00_0000 (exit) are ordinary bus writes; no special handling.

Test Plan:
- Word load, addr 0x0800_0010, memory bytes 12 34 56 78, ACK after 1 cycle -> MREQ=1, WRITE=0, SIZE=00 for exactly one cycle; resp_valid next cycle; resp_rdata=0x1234_5678, resp_err=0.
- Signed halfword load, addr 0x0800_0002, DDT[15:0]=0x8001 -> resp_rdata=0xFFFF_8001. Unsigned -> 0x0000_8001.
- Byte store of wdata 0xAABB_CC41 to 0xF000_0000, SIZE=10, ACK delayed 3 cycles -> DDT=0x0000_0041 and DAD/SIZE/WRITE stable all 3 cycles; DDT=Z after MREQ falls; one resp_valid.
- Word store to 0x0800_0006 -> no MREQ; resp_valid one cycle after acceptance with resp_err=1, resp_rdata=0.
- Load with ACKD_n held high, TIMEOUT=8 -> MREQ high for 8 cycles then low; resp_err=1. A following aligned load completes normally.
- rst=1 during BUS of a store -> after that edge MREQ=0, DDT=Z, busy=0; no resp_valid; a late ACKD_n=0 is ignored.

Source files
------------

// File: rtl/dmem_bus_master.sv
// Processor-side initiator for the data-memory bus: runs one load/store handshake
// at a time, places store lanes on DDT, extends load data and reports misalignment/timeout.
module dmem_bus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 256,
  parameter int CNT_W     = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic                 busy,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  output logic [1:0]           state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester holds its fields stable until then. resp_valid is a one-cycle pulse.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic                 signed_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic                 misaligned;
  logic                 cnt_last;

  function automatic logic [BIT_WIDTH-1:0] place_lanes(input logic [1:0] size,
                                                        input logic [BIT_WIDTH-1:0] data);
    case (size)
      2'b00:   place_lanes = data;
      2'b01:   place_lanes = {{(BIT_WIDTH-16){1'b0}}, data[15:0]};
      default: place_lanes = {{(BIT_WIDTH-8){1'b0}}, data[7:0]};
    endcase
  endfunction

  function automatic logic [BIT_WIDTH-1:0] extend_load(input logic [1:0] size,
                                                        input logic sgn,
                                                        input logic [BIT_WIDTH-1:0] data);
    case (size)
      2'b00:   extend_load = data;
      2'b01:   extend_load = {{(BIT_WIDTH-16){sgn & data[15]}}, data[15:0]};
      default: extend_load = {{(BIT_WIDTH-8){sgn & data[7]}}, data[7:0]};
    endcase
  endfunction

  assign misaligned = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'b01) && req_addr[0]);
  assign cnt_last   = (cnt == CNT_W'(TIMEOUT - 1));

  // Only the initiator drives DDT, and only while a write cycle is on the bus.
  assign DDT = (MREQ && WRITE) ? wdata_q : {BIT_WIDTH{1'bz}};

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    unique case (state)
      S_IDLE: if (req_valid) state_nx = misaligned ? S_DONE : S_BUS;
      S_BUS:  if (!ACKD_n || cnt_last) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin : output_decode
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin : datapath
    if (rst) begin
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
      DAD        <= '0;
      cnt        <= '0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= (state_nx == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              DAD      <= req_addr;
              SIZE     <= req_size;
              WRITE    <= req_write;
              signed_q <= req_signed;
              wdata_q  <= place_lanes(req_size, req_wdata);
              MREQ     <= 1'b1;
              cnt      <= '0;
            end
          end
        end
        S_BUS: begin
          if (!ACKD_n) begin
            MREQ       <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= WRITE ? '0 : extend_load(SIZE, signed_q, DDT);
          end else if (cnt_last) begin
            MREQ       <= 1'b0;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master with a small timeout so the abort path is reachable.
module tb_dmem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] dad;
  logic        mreq;
  logic        write;
  logic [1:0]  size;
  logic        ackd_n;
  wire  [31:0] ddt;
  logic [1:0]  state_dbg;

  logic        mem_oe;
  logic [31:0] mem_data;
  int          checks = 0;
  int          errors = 0;
  int          n_high;

  assign ddt = mem_oe ? mem_data : 32'bz;

  dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT(8), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .DAD(dad), .MREQ(mreq), .WRITE(write), .SIZE(size),
    .ACKD_n(ackd_n), .DDT(ddt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Undriven DDT reads as Z in a 4-state simulator and as 0 in a 2-state one.
  task automatic check_hiz(input string tag);
    check(tag, 32'((ddt === 32'bz) || (ddt === 32'h0)), 32'd1);
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    check("req_ready_before_accept", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ack_cycle(input logic drive, input logic [31:0] data);
    ackd_n   = 1'b0;
    mem_oe   = drive;
    mem_data = data;
    tick();
    ackd_n = 1'b1;
    mem_oe = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_rdata"}, resp_rdata, rdata);
    check({tag, "_err"},   32'(resp_err), 32'(err));
    check({tag, "_mreq_low"}, 32'(mreq), 32'd0);
    tick();
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(req_ready), 32'd1);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] bus, input logic [31:0] exp);
    issue(1'b0, sz, sg, addr, 32'h0);
    check({tag, "_mreq"}, 32'(mreq), 32'd1);
    check({tag, "_size"}, 32'(size), 32'(sz));
    check({tag, "_dad"}, dad, addr);
    ack_cycle(1'b1, bus);
    check_resp(tag, exp, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    ackd_n = 1'b1; mem_oe = 1'b0; mem_data = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_mreq", 32'(mreq), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_size", 32'(size), 32'd0);
    check("rst_dad", dad, 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'd0);
    check_hiz("rst_ddt");

    // Word load, single-cycle memory: MREQ for exactly one cycle
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0);
    check("wl_mreq", 32'(mreq), 32'd1);
    check("wl_write", 32'(write), 32'd0);
    check("wl_size", 32'(size), 32'd0);
    check("wl_dad", dad, 32'h0800_0010);
    check("wl_busy", 32'(busy), 32'd1);
    check("wl_ready_low", 32'(req_ready), 32'd0);
    check("wl_state_bus", 32'(state_dbg), 32'd1);
    ack_cycle(1'b1, 32'h1234_5678);
    check("wl_state_done", 32'(state_dbg), 32'd2);
    check("wl_ready_done", 32'(req_ready), 32'd0);
    check_resp("wl", 32'h1234_5678, 1'b0);
    check("wl_rdata_hold", resp_rdata, 32'h1234_5678);

    // Halfword and byte loads; upper DDT bits carry junk that must be dropped
    load("lh_s", 2'b01, 1'b1, 32'h0800_0002, 32'hDEAD_8001, 32'hFFFF_8001);
    load("lh_u", 2'b01, 1'b0, 32'h0800_0002, 32'hDEAD_8001, 32'h0000_8001);
    load("lh_s_pos", 2'b01, 1'b1, 32'h0800_0004, 32'hFFFF_7FFE, 32'h0000_7FFE);
    load("lb_s", 2'b10, 1'b1, 32'h0800_0003, 32'h1234_56F0, 32'hFFFF_FFF0);
    load("lb_u", 2'b11, 1'b0, 32'h0800_0003, 32'h1234_56F0, 32'h0000_00F0);
    load("lw_sign_ignored", 2'b00, 1'b1, 32'h0800_0000, 32'h8000_0001, 32'h8000_0001);

    // Byte store to console, ack on the third BUS cycle
    issue(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hAABB_CC41);
    for (int c = 0; c < 3; c++) begin
      check("sb_mreq", 32'(mreq), 32'd1);
      check("sb_write", 32'(write), 32'd1);
      check("sb_size", 32'(size), 32'd2);
      check("sb_dad", dad, 32'hF000_0000);
      check("sb_ddt", ddt, 32'h0000_0041);
      check("sb_no_resp", 32'(resp_valid), 32'd0);
      if (c < 2) tick();
    end
    ack_cycle(1'b0, 32'h0);
    check_hiz("sb_ddt_released");
    check_resp("sb", 32'h0, 1'b0);

    // Halfword and word store lane placement
    issue(1'b1, 2'b01, 1'b0, 32'h0800_0002, 32'h1234_5678);
    check("sh_ddt", ddt, 32'h0000_5678);
    ack_cycle(1'b0, 32'h0);
    check_resp("sh", 32'h0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'hFF00_0000, 32'hCAFE_F00D);
    check("sw_ddt", ddt, 32'hCAFE_F00D);
    ack_cycle(1'b0, 32'h0);
    check_resp("sw", 32'h0, 1'b0);

    // Misaligned accesses never reach the bus; rdata cleared after a prior load
    load("lw_pre", 2'b00, 1'b0, 32'h0800_0008, 32'h5555_AAAA, 32'h5555_AAAA);
    issue(1'b1, 2'b00, 1'b0, 32'h0800_0006, 32'h1111_2222);
    check("mis_sw_mreq", 32'(mreq), 32'd0);
    check_resp("mis_sw", 32'h0, 1'b1);
    issue(1'b0, 2'b01, 1'b1, 32'h0800_0001, 32'h0);
    check("mis_lh_mreq", 32'(mreq), 32'd0);
    check_resp("mis_lh", 32'h0, 1'b1);

    // Timeout: ACKD_n never falls
    issue(1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h0);
    n_high = 0;
    while (mreq && n_high < 20) begin
      n_high++;
      tick();
    end
    check("tmo_mreq_cycles", 32'(n_high), 32'd8);
    check_resp("tmo", 32'h0, 1'b1);
    load("after_tmo", 2'b00, 1'b0, 32'h0800_0024, 32'h0BAD_BEEF, 32'h0BAD_BEEF);

    // ACKD_n low while idle is ignored
    ackd_n = 1'b0;
    tick();
    tick();
    check("idle_ack_no_resp", 32'(resp_valid), 32'd0);
    check("idle_ack_busy", 32'(busy), 32'd0);
    ackd_n = 1'b1;

    // Reset during BUS of a store abandons it
    issue(1'b1, 2'b00, 1'b0, 32'h0800_0030, 32'h7777_8888);
    check("rstbus_mreq_before", 32'(mreq), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstbus_mreq", 32'(mreq), 32'd0);
    check("rstbus_busy", 32'(busy), 32'd0);
    check("rstbus_no_resp", 32'(resp_valid), 32'd0);
    check_hiz("rstbus_ddt");
    ackd_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rstbus_late_ack_no_resp", 32'(resp_valid), 32'd0);
      check("rstbus_late_ack_mreq", 32'(mreq), 32'd0);
    end
    ackd_n = 1'b1;
    load("after_rst", 2'b10, 1'b0, 32'h0800_0031, 32'h0000_0099, 32'h0000_0099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
